load_fsm: RTL

LOAD_FSM -- requirements
Module: load_fsm

---
 rtl/shake_pkg.sv | 36 +++
 rtl/pad_unit.sv | 28 ++
 rtl/load_fsm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/shake_pkg.sv
// shake_pkg: shared constants, state type and helpers for the SHAKE block loader.
package shake_pkg;

    localparam int WORD_WIDTH          = 64;
    localparam int SHAKE128_RATE_WORDS = 21;
    localparam int SHAKE256_RATE_WORDS = 17;
    localparam int MAX_RATE_WORDS      = SHAKE128_RATE_WORDS;
    localparam int BLOCK_WIDTH         = WORD_WIDTH * MAX_RATE_WORDS;
    localparam int BLOCK_BYTES         = BLOCK_WIDTH / 8;

    localparam logic [7:0] PAD_BYTE = 8'h1F;
    localparam logic [7:0] PAD_LAST = 8'h80;

    typedef enum logic [1:0] {
        StIdle,
        StAbsorb,
        StPad,
        StFlush
    } load_state_e;

    // Rate in 64-bit words for the selected SHAKE variant (0: SHAKE128, 1: SHAKE256).
    function automatic logic [4:0] rate_words(input logic mode);
        return mode ? 5'(SHAKE256_RATE_WORDS) : 5'(SHAKE128_RATE_WORDS);
    endfunction

    // Keeps bytes 0..nbytes-1 of a word, zeroes the rest.
    function automatic logic [WORD_WIDTH-1:0] byte_mask(input logic [3:0] nbytes);
        logic [WORD_WIDTH-1:0] mask;
        mask = '0;
        for (int k = 0; k < 8; k++) begin
            mask[k*8 +: 8] = (4'(k) < nbytes) ? 8'hFF : 8'h00;
        end
        return mask;
    endfunction

endpackage

// File: rtl/pad_unit.sv
// pad_unit: applies SHAKE pad10*1 with domain byte to a rate block.
// Bytes at and above p_i are expected to be zero on entry.
module pad_unit
    import shake_pkg::*;
(
    input  logic [BLOCK_WIDTH-1:0] block_i,
    input  logic [7:0]             p_i,
    input  logic [4:0]             rate_i,
    output logic [BLOCK_WIDTH-1:0] block_o
);

    logic [7:0] last_byte;

    // Write the domain byte at p_i and OR the final-bit marker into the last rate byte.
    always_comb begin
        last_byte = {rate_i, 3'b000} - 8'd1;
        block_o   = block_i;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (p_i == 8'(k)) begin
                block_o[k*8 +: 8] = PAD_BYTE;
            end
            if (last_byte == 8'(k)) begin
                block_o[k*8 +: 8] = block_o[k*8 +: 8] | PAD_LAST;
            end
        end
    end

endmodule

// File: rtl/load_fsm.sv
// load_fsm: collects 64-bit message words into SHAKE128/256 rate blocks and hands
// them to the permutation stage. Define LOAD_PAD_EN to pad in hardware; without it
// the input is assumed already padded and last_bytes_in is ignored.
module load_fsm
    import shake_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [63:0]            data_in,
    input  logic                   last_in,
    input  logic [3:0]             last_bytes_in,
    input  logic                   mode_in,
    output logic [BLOCK_WIDTH-1:0] block_out,
    output logic                   block_valid_out,
    input  logic                   block_ready_in,
    output logic                   last_block_out,
    output logic                   mode_out
);

    load_state_e            state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [BLOCK_WIDTH-1:0] buf_q, buf_d;
    logic                   mode_q, mode_d;
    logic                   last_q, last_d;

    logic                   in_ready;
    logic                   accept;
    logic [4:0]             idx;
    logic [4:0]             rate;
    logic [WORD_WIDTH-1:0]  word;

`ifdef LOAD_PAD_EN
    logic                   pad_pending_q, pad_pending_d;
    logic [7:0]             pad_p_q, pad_p_d;
    logic [3:0]             lb;
    logic [BLOCK_WIDTH-1:0] padded;

    pad_unit u_pad_unit (
        .block_i (buf_q),
        .p_i     (pad_p_q),
        .rate_i  (rate_words(mode_q)),
        .block_o (padded)
    );
`else
    logic unused_last_bytes;
    assign unused_last_bytes = ^last_bytes_in;
`endif

    assign in_ready = (state_q == StIdle) || (state_q == StAbsorb);

    // Next-state logic: word capture, block completion, padding and handoff.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        last_d  = last_q;
`ifdef LOAD_PAD_EN
        pad_pending_d = pad_pending_q;
        pad_p_d       = pad_p_q;
        lb            = (last_bytes_in > 4'd8) ? 4'd8 : last_bytes_in;
`endif
        accept = in_ready && valid_in;
        // The first word of a message uses the incoming mode before it is latched.
        idx    = (state_q == StIdle) ? 5'd0 : cnt_q;
        rate   = rate_words((state_q == StIdle) ? mode_in : mode_q);
        word   = data_in;
`ifdef LOAD_PAD_EN
        if (last_in) begin
            word = data_in & byte_mask(lb);
        end
`endif

        unique case (state_q)
            StIdle, StAbsorb: begin
                if (accept) begin
                    if (state_q == StIdle) begin
                        mode_d = mode_in;
                    end
                    for (int i = 0; i < MAX_RATE_WORDS; i++) begin
                        if (idx == 5'(i)) begin
                            buf_d[i*WORD_WIDTH +: WORD_WIDTH] = word;
                        end
                    end
                    cnt_d = idx + 5'd1;
                    if (last_in) begin
`ifdef LOAD_PAD_EN
                        if ((idx == rate - 5'd1) && (lb == 4'd8)) begin
                            // Message ends on the block boundary: padding needs a fresh block.
                            state_d       = StFlush;
                            last_d        = 1'b0;
                            pad_pending_d = 1'b1;
                        end else begin
                            state_d = StPad;
                            pad_p_d = {idx, 3'b000} + {4'b0000, lb};
                        end
`else
                        state_d = StFlush;
                        last_d  = 1'b1;
`endif
                    end else if (idx == rate - 5'd1) begin
                        state_d = StFlush;
                        last_d  = 1'b0;
                    end else begin
                        state_d = StAbsorb;
                    end
                end
            end
            StPad: begin
`ifdef LOAD_PAD_EN
                buf_d   = padded;
                last_d  = 1'b1;
                state_d = StFlush;
`else
                state_d = StIdle;
`endif
            end
            StFlush: begin
                if (block_ready_in) begin
                    buf_d  = '0;
                    cnt_d  = 5'd0;
                    last_d = 1'b0;
`ifdef LOAD_PAD_EN
                    if (pad_pending_q) begin
                        state_d       = StPad;
                        pad_p_d       = 8'd0;
                        pad_pending_d = 1'b0;
                    end else if (last_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StAbsorb;
                    end
`else
                    state_d = last_q ? StIdle : StAbsorb;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset abandons any partial message.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '0;
            mode_q  <= 1'b0;
            last_q  <= 1'b0;
`ifdef LOAD_PAD_EN
            pad_pending_q <= 1'b0;
            pad_p_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
`ifdef LOAD_PAD_EN
            pad_pending_q <= pad_pending_d;
            pad_p_q       <= pad_p_d;
`endif
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign ready_out       = in_ready && !rst;
    assign block_valid_out = (state_q == StFlush) && !rst;
    assign last_block_out  = last_q && !rst;
    assign mode_out        = mode_q && !rst;
    assign block_out       = buf_q;

endmodule
